// File: rtl/fft8_pkg.sv
// Shared types, constants and schedule helpers for the 8-point radix-2 DIT FFT controller.
package fft8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        UNLOAD
    } state_t;

    localparam int unsigned NPTS = 8;
    localparam int unsigned NSTG = 3;
    localparam int unsigned NBF  = 4;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
    } addr_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // a = ((k>>s)<<(s+1)) + pos, b = a + span, tw = pos << (2-s), unrolled per stage
    function automatic addr_t addr_gen(input logic [1:0] s, input logic [1:0] k);
        addr_t r;
        case (s)
            2'd1: begin
                r.a  = {k[1], 1'b0, k[0]};
                r.b  = r.a + 3'd2;
                r.tw = {k[0], 1'b0};
            end
            2'd2: begin
                r.a  = {1'b0, k};
                r.b  = r.a + 3'd4;
                r.tw = k;
            end
            default: begin
                r.a  = {k, 1'b0};
                r.b  = r.a + 3'd1;
                r.tw = 2'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fft8_addr_gen.sv
// Combinational butterfly schedule: (stage, butterfly) -> operand addresses and twiddle exponent.
module fft8_addr_gen
    import fft8_pkg::*;
(
    input  logic [1:0] stg,
    input  logic [1:0] bf,
    output logic [2:0] a,
    output logic [2:0] b,
    output logic [1:0] tw
);

    addr_t sched;

    always_comb begin
        sched = addr_gen(stg, bf);
        a     = sched.a;
        b     = sched.b;
        tw    = sched.tw;
    end

endmodule

// File: rtl/fft8_ctrl.sv
// 8-point FFT sequencer/operand buffer driving one shared external butterfly unit.
// Optional FFT8_CTRL_SCALE_EN: arithmetic >>1 of every write-back part (output = DFT/8).
module fft8_ctrl
    import fft8_pkg::*;
#(
    parameter int N = 3,
    localparam int W = 2 ** N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
    output logic           out_last,
    output logic           bf_valid,
    input  logic           bf_ready,
    output logic [2*W-1:0] bf_a,
    output logic [2*W-1:0] bf_b,
    output logic [1:0]     bf_tw,
    input  logic           res_valid,
    input  logic [2*W-1:0] res_x,
    input  logic [2*W-1:0] res_y,
    output logic           busy
);

    state_t         state_q, state_d;
    logic [2:0]     ld_cnt_q, ld_cnt_d;
    logic [2:0]     ul_cnt_q, ul_cnt_d;
    logic [1:0]     bf_cnt_q, bf_cnt_d;
    logic [1:0]     stg_q, stg_d;
    logic [2*W-1:0] mem_q [NPTS];
    logic [2*W-1:0] mem_d [NPTS];
    logic [2:0]     op_a, op_b;
    logic [1:0]     op_tw;

    fft8_addr_gen u_addr_gen (
        .stg (stg_q),
        .bf  (bf_cnt_q),
        .a   (op_a),
        .b   (op_b),
        .tw  (op_tw)
    );

    function automatic logic [2*W-1:0] wb(input logic [2*W-1:0] v);
`ifdef FFT8_CTRL_SCALE_EN
        return {v[2*W-1], v[2*W-1:W+1], v[W-1], v[W-1:1]};
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        ul_cnt_d  = ul_cnt_q;
        bf_cnt_d  = bf_cnt_q;
        stg_d     = stg_q;
        mem_d     = mem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        bf_valid  = 1'b0;
        bf_a      = '0;
        bf_b      = '0;
        bf_tw     = '0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE, LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_d[bitrev3(ld_cnt_q)] = in_data;
                    ld_cnt_d = ld_cnt_q + 3'd1;
                    state_d  = (ld_cnt_q == 3'(NPTS - 1)) ? ISSUE : LOAD;
                end
            end
            ISSUE: begin
                bf_valid = 1'b1;
                bf_a     = mem_q[op_a];
                bf_b     = mem_q[op_b];
                bf_tw    = op_tw;
                if (bf_ready) state_d = WAIT;
            end
            WAIT: begin
                if (res_valid) begin
                    mem_d[op_a] = wb(res_x);
                    mem_d[op_b] = wb(res_y);
                    bf_cnt_d    = bf_cnt_q + 2'd1;
                    state_d     = ISSUE;
                    if (bf_cnt_q == 2'(NBF - 1)) begin
                        if (stg_q == 2'(NSTG - 1)) begin
                            stg_d   = '0;
                            state_d = UNLOAD;
                        end else begin
                            stg_d = stg_q + 2'd1;
                        end
                    end
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_data  = mem_q[ul_cnt_q];
                out_last  = (ul_cnt_q == 3'(NPTS - 1));
                if (out_ready) begin
                    ul_cnt_d = ul_cnt_q + 3'd1;
                    if (ul_cnt_q == 3'(NPTS - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ld_cnt_q <= '0;
            ul_cnt_q <= '0;
            bf_cnt_q <= '0;
            stg_q    <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            ul_cnt_q <= ul_cnt_d;
            bf_cnt_q <= bf_cnt_d;
            stg_q    <= stg_d;
        end
    end

    // Operand buffer carries no reset; stale contents are never exposed outside ISSUE/UNLOAD.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fft8_ctrl.sv
// Scoreboard bench for fft8_ctrl: stimulus pushes expected operands/results, monitors pop and compare.
module tb_fft8_ctrl;

    logic        clk = 1'b0;
    logic        rst, rst_main, rst_abort;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [15:0] out_data;
    logic        bf_valid, bf_ready;
    logic [15:0] bf_a, bf_b;
    logic [1:0]  bf_tw;
    logic        res_valid;
    logic [15:0] res_x, res_y;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  tw;
    } op_t;

    op_t         op_q[$];
    logic [16:0] out_q[$];

    bit stall_mode = 1'b0;
    bit rand_oready = 1'b0;
    int abort_op = -1;
    int abort_cnt = 0;

    int sa[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int sb[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int stw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    assign rst = rst_main | rst_abort;

    always #5 clk = ~clk;

    fft8_ctrl #(.N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .bf_valid  (bf_valid),
        .bf_ready  (bf_ready),
        .bf_a      (bf_a),
        .bf_b      (bf_b),
        .bf_tw     (bf_tw),
        .res_valid (res_valid),
        .res_x     (res_x),
        .res_y     (res_y),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference datapath: x = a + W8^k*b, y = a - W8^k*b, 1/sqrt2 ~ 181/256
    function automatic logic [31:0] bfly(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] tw);
        int ar, ai, br, bi, tr, ti;
        ar = int'($signed(a[15:8]));
        ai = int'($signed(a[7:0]));
        br = int'($signed(b[15:8]));
        bi = int'($signed(b[7:0]));
        case (tw)
            2'd1: begin tr = ((br + bi) * 181) >>> 8; ti = ((bi - br) * 181) >>> 8; end
            2'd2: begin tr = bi; ti = -br; end
            2'd3: begin tr = ((bi - br) * 181) >>> 8; ti = (-(br + bi) * 181) >>> 8; end
            default: begin tr = br; ti = bi; end
        endcase
        return {8'(ar + tr), 8'(ai + ti), 8'(ar - tr), 8'(ai - ti)};
    endfunction

    function automatic logic [15:0] halve(input logic [15:0] v);
`ifdef FFT8_CTRL_SCALE_EN
        int re, im;
        re = int'($signed(v[15:8])) >>> 1;
        im = int'($signed(v[7:0])) >>> 1;
        return {8'(re), 8'(im)};
`else
        return v;
`endif
    endfunction

    // Runs the frame through a software FFT, queueing expected operands and results.
    task automatic model_frame(input logic [15:0] s[8], input bit use_hand, input logic [15:0] hand[8]);
        logic [15:0] m[8];
        logic [31:0] xy;
        for (int i = 0; i < 8; i++) m[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)] = s[i];
        for (int o = 0; o < 12; o++) begin
            op_q.push_back('{a: m[sa[o]], b: m[sb[o]], tw: 2'(stw[o])});
            xy = bfly(m[sa[o]], m[sb[o]], 2'(stw[o]));
            m[sa[o]] = halve(xy[31:16]);
            m[sb[o]] = halve(xy[15:0]);
        end
        for (int i = 0; i < 8; i++) out_q.push_back({i == 7, use_hand ? hand[i] : m[i]});
    endtask

    task automatic send_frame(input logic [15:0] s[8]);
        bit acc;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            acc = 1'b0;
            for (int t = 0; t < 1000 && !acc; t++) begin
                #1;
                if (out_valid) chk("in_ready_unload", 32'(in_ready), 0);
                if (!busy) chk("in_ready_idle", 32'(in_ready), 1);
                acc = in_ready;
                @(negedge clk);
            end
            if (!acc) chk("load_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            #1;
            done = (out_q.size() == 0) && (op_q.size() == 0) && !busy;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    // Butterfly datapath emulation with random latency, optional stall and mid-op reset.
    initial begin
        op_t e, cap;
        logic [31:0] xy;
        int lat, op_idx;
        bf_ready = 1'b0; res_valid = 1'b0; res_x = '0; res_y = '0; rst_abort = 1'b0;
        op_idx = 0;
        forever begin
            @(negedge clk);
            if (bf_valid && !rst) begin
                cap = '{a: bf_a, b: bf_b, tw: bf_tw};
                if (stall_mode) begin
                    for (int c = 0; c < 7; c++) begin
                        @(negedge clk);
                        chk("bf_valid_held", 32'(bf_valid), 1);
                        chk("bf_a_stable", 32'(bf_a), 32'(cap.a));
                        chk("bf_b_stable", 32'(bf_b), 32'(cap.b));
                        chk("bf_tw_stable", 32'(bf_tw), 32'(cap.tw));
                    end
                end
                if (op_q.size() == 0) begin
                    chk("op_unexpected", 0, 1);
                end else begin
                    e = op_q.pop_front();
                    chk("op_a", 32'(bf_a), 32'(e.a));
                    chk("op_b", 32'(bf_b), 32'(e.b));
                    chk("op_tw", 32'(bf_tw), 32'(e.tw));
                end
                xy = bfly(bf_a, bf_b, bf_tw);
                bf_ready = 1'b1;
                @(negedge clk);
                bf_ready = 1'b0;
                if (op_idx == abort_op) begin
                    rst_abort = 1'b1;
                    @(negedge clk);
                    rst_abort = 1'b0;
                    #1;
                    chk("abort_busy", 32'(busy), 0);
                    chk("abort_in_ready", 32'(in_ready), 1);
                    op_q.delete();
                    out_q.delete();
                    @(negedge clk);
                    res_valid = 1'b1;
                    res_x = 16'h7f7f;
                    res_y = 16'h8181;
                    @(negedge clk);
                    res_valid = 1'b0;
                    #1;
                    chk("late_res_busy", 32'(busy), 0);
                    chk("late_res_bf_valid", 32'(bf_valid), 0);
                    op_idx = 0;
                    abort_cnt++;
                end else begin
                    lat = $urandom_range(0, 5);
                    repeat (lat) @(negedge clk);
                    res_valid = 1'b1;
                    res_x = xy[31:16];
                    res_y = xy[15:0];
                    @(negedge clk);
                    res_valid = 1'b0;
                    op_idx = (op_idx == 11) ? 0 : op_idx + 1;
                end
            end
        end
    end

    // Output monitor: pops expected result on each transfer, checks stability while stalled.
    initial begin
        logic [16:0] prev, e;
        bit prev_stall;
        out_ready = 1'b0;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("out_valid_held", 32'(out_valid), 1);
                chk("out_stable", 32'({out_last, out_data}), 32'(prev));
            end
            if (out_valid) begin
                out_ready = rand_oready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    if (out_q.size() == 0) begin
                        chk("out_unexpected", 0, 1);
                    end else begin
                        e = out_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e[15:0]));
                        chk("out_last", 32'(out_last), 32'(e[16]));
                    end
                end
                prev_stall = !out_ready;
                prev = {out_last, out_data};
            end else begin
                out_ready = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        repeat (40000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fr[8], hand[8];
        int start_abort;
        in_valid = 1'b0;
        in_data  = '0;
        rst_main = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_bf_valid", 32'(bf_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bf_tw", 32'(bf_tw), 0);
        chk("rst_bf_a", 32'(bf_a), 0);
        chk("rst_bf_b", 32'(bf_b), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(negedge clk);
        rst_main = 1'b0;
        @(negedge clk);

        // Distinct samples expose the operand schedule
        for (int i = 0; i < 8; i++) fr[i] = {8'(3 * i + 1), 8'(5 - 2 * i)};
        model_frame(fr, 1'b0, hand);
        send_frame(fr);
        wait_idle();

        // Impulse
        for (int i = 0; i < 8; i++) fr[i] = (i == 0) ? 16'h1000 : 16'h0000;
`ifdef FFT8_CTRL_SCALE_EN
        for (int i = 0; i < 8; i++) hand[i] = 16'h0200;
`else
        for (int i = 0; i < 8; i++) hand[i] = 16'h1000;
`endif
        model_frame(fr, 1'b1, hand);
        send_frame(fr);
        wait_idle();

        // DC under backpressure, followed immediately by a frame offered while busy
        stall_mode  = 1'b1;
        rand_oready = 1'b1;
        for (int i = 0; i < 8; i++) fr[i] = 16'h0a00;
`ifdef FFT8_CTRL_SCALE_EN
        for (int i = 0; i < 8; i++) hand[i] = (i == 0) ? 16'h0a00 : 16'h0000;
`else
        for (int i = 0; i < 8; i++) hand[i] = (i == 0) ? 16'h5000 : 16'h0000;
`endif
        model_frame(fr, 1'b1, hand);
        send_frame(fr);
        for (int i = 0; i < 8; i++) fr[i] = {8'(7 - 5 * i), 8'(2 * i - 9)};
        model_frame(fr, 1'b0, hand);
        send_frame(fr);
        wait_idle();
        stall_mode  = 1'b0;
        rand_oready = 1'b0;

        // Reset during WAIT of the sixth op, then a clean impulse frame
        start_abort = abort_cnt;
        abort_op = 5;
        for (int i = 0; i < 8; i++) fr[i] = {8'(i * 11), 8'(i - 4)};
        model_frame(fr, 1'b0, hand);
        send_frame(fr);
        for (int t = 0; t < 2000 && abort_cnt == start_abort; t++) @(negedge clk);
        chk("abort_seen", 32'(abort_cnt - start_abort), 1);
        abort_op = -1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) fr[i] = (i == 0) ? 16'h1000 : 16'h0000;
`ifdef FFT8_CTRL_SCALE_EN
        for (int i = 0; i < 8; i++) hand[i] = 16'h0200;
`else
        for (int i = 0; i < 8; i++) hand[i] = 16'h1000;
`endif
        model_frame(fr, 1'b1, hand);
        send_frame(fr);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
